// File: rtl/mem_out_if.sv
// ---------------------------------------------------------------------------
// mem_out_if : packed per-bank SRAM bus (enables, address, data in/out)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_out_if #(
  parameter int word_len   = 32,
  parameter int sram_addr  = 8,
  parameter int sram_count = 16
);
  logic [sram_count-1:0]           CEN;
  logic [sram_count-1:0]           WEN;
  logic [sram_count*sram_addr-1:0] A;
  logic [sram_count*word_len-1:0]  D;
  logic [sram_count*word_len-1:0]  Q;

  modport master (output CEN, output WEN, output A, output D, input Q);
  modport slave  (input CEN, input WEN, input A, input D, output Q);
endinterface

`default_nettype wire

// File: rtl/mem_out.sv
// ---------------------------------------------------------------------------
// mem_out : sram_count independent single-port SRAM banks with registered Q.
// Optional macro MEM_OUT_WRITE_THROUGH_EN: Q also loads write data on writes.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_out #(
  parameter int word_len   = 32,
  parameter int sram_addr  = 8,
  parameter int sram_count = 16
) (
  input  logic     clk,
  input  logic     resetn,
  mem_out_if.slave bus
);

  localparam int c_depth = 1 << sram_addr;

  genvar k;
  generate
    for (k = 0; k < sram_count; k++) begin : g_bank
      logic [word_len-1:0]  r_mem [c_depth];
      logic [word_len-1:0]  r_q;
      logic [sram_addr-1:0] w_addr;
      logic [word_len-1:0]  w_din;
      logic                 w_cen;
      logic                 w_wen;
      logic                 w_known;

      assign w_cen  = bus.CEN[k];
      assign w_wen  = bus.WEN[k];
      assign w_addr = bus.A[sram_addr*k +: sram_addr];
      assign w_din  = bus.D[word_len*k +: word_len];
      // An unknown address or data bit drops the write instead of corrupting the array
      assign w_known = ((^{w_addr, w_din}) !== 1'bx);

      // Array has no reset: contents survive resetn, writes are blocked while it is low
      always_ff @(posedge clk) begin
        if (resetn && !w_cen && !w_wen && w_known) begin
          r_mem[w_addr] <= w_din;
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_q <= '0;
        end else if (!w_cen) begin
          if (w_wen) begin
            r_q <= r_mem[w_addr];
          end
`ifdef MEM_OUT_WRITE_THROUGH_EN
          else begin
            r_q <= w_din;
          end
`endif
        end
      end

      assign bus.Q[word_len*k +: word_len] = r_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mem_out.sv
// ---------------------------------------------------------------------------
// tb_mem_out : directed vector bench for mem_out (fill/readback, hold, reset)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_out;

  localparam int c_w  = 32;
  localparam int c_aw = 8;
  localparam int c_n  = 16;
`ifdef MEM_OUT_WRITE_THROUGH_EN
  localparam bit c_wt = 1'b1;
`else
  localparam bit c_wt = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_fail;

  mem_out_if #(.word_len(c_w), .sram_addr(c_aw), .sram_count(c_n)) bus ();

  mem_out #(.word_len(c_w), .sram_addr(c_aw), .sram_count(c_n)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          bank;
    logic        cen;
    logic        wen;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] q_of(input int k);
    return bus.Q[c_w*k +: c_w];
  endfunction

  task automatic set_bank(input int k, input logic cen, input logic wen,
                          input logic [7:0] a, input logic [31:0] d);
    bus.CEN[k]            = cen;
    bus.WEN[k]            = wen;
    bus.A[c_aw*k +: c_aw] = a;
    bus.D[c_w*k +: c_w]   = d;
  endtask

  task automatic idle_all();
    bus.CEN = '1;
    bus.WEN = '1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    bus.CEN  = '1;
    bus.WEN  = '1;
    bus.A    = '0;
    bus.D    = '0;

    vt[0] = '{"rd_b2_a0",   2,  1'b0, 1'b1, 8'd0,   32'h0,    1'b1, 32'd2};
    vt[1] = '{"wr_hold_b2", 2,  1'b0, 1'b0, 8'd9,   32'h1234, 1'b1, c_wt ? 32'h1234 : 32'd2};
    vt[2] = '{"rd_b2_a9",   2,  1'b0, 1'b1, 8'd9,   32'h0,    1'b1, 32'h1234};
    vt[3] = '{"rd_b2_a10",  2,  1'b0, 1'b1, 8'd10,  32'h0,    1'b1, 32'd12};
    vt[4] = '{"idle_b2",    2,  1'b1, 1'b1, 8'd3,   32'h0,    1'b1, 32'd12};
    vt[5] = '{"rd_b15_255", 15, 1'b0, 1'b1, 8'd255, 32'h0,    1'b1, 32'h10E};
    vt[6] = '{"wr_b15_255", 15, 1'b0, 1'b0, 8'd255, 32'hDEAD, 1'b1, c_wt ? 32'hDEAD : 32'h10E};
    vt[7] = '{"rd_b5_250",  5,  1'b0, 1'b1, 8'd250, 32'h0,    1'b1, 32'd255};

    // Reset state
    repeat (2) tick();
    for (int k = 0; k < c_n; k++) check("reset_q", q_of(k), 32'h0);
    #2 resetn = 1'b1;
    tick();

    // Fill all banks: mem_k[i] = k + i
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < c_n; k++) set_bank(k, 1'b0, 1'b0, 8'(i), 32'(k + i));
      tick();
    end

    // Readback with one cycle latency
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < c_n; k++) set_bank(k, 1'b0, 1'b1, 8'(i), 32'h0);
      tick();
      for (int k = 0; k < c_n; k++) check("fill_readback", q_of(k), 32'(k + i));
    end

    // Idle hold on bank 3
    for (int k = 0; k < c_n; k++) set_bank(k, 1'b0, 1'b1, 8'd0, 32'h0);
    set_bank(3, 1'b0, 1'b1, 8'd4, 32'h0);
    tick();
    check("rd_b3_a4", q_of(3), 32'd7);
    for (int k = 0; k < c_n; k++) set_bank(k, 1'b0, 1'b1, 8'd1, 32'h0);
    set_bank(3, 1'b1, 1'b1, 8'd100, 32'h0);
    tick();
    check("idle_hold_b3", q_of(3), 32'd7);
    check("other_b0", q_of(0), 32'd1);
    check("other_b4", q_of(4), 32'd5);

    // Asynchronous reset mid-cycle clears Q before the next edge
    #2 resetn = 1'b0;
    #1;
    for (int k = 0; k < c_n; k++) check("async_reset_q", q_of(k), 32'h0);
    idle_all();
    tick();
    #2 resetn = 1'b1;
    tick();

    // Same edge: bank 0 writes, bank 1 reads
    idle_all();
    set_bank(0, 1'b0, 1'b0, 8'd5, 32'hAAAA_5555);
    set_bank(1, 1'b0, 1'b1, 8'd5, 32'h0);
    tick();
    check("indep_b1_rd", q_of(1), 32'd6);
    idle_all();
    set_bank(0, 1'b0, 1'b1, 8'd5, 32'h0);
    tick();
    check("indep_b0_rd", q_of(0), 32'hAAAA_5555);

    // Single-bank vector table
    for (int v = 0; v < 8; v++) begin
      idle_all();
      set_bank(vt[v].bank, vt[v].cen, vt[v].wen, vt[v].addr, vt[v].data);
      tick();
      if (vt[v].chk) check(vt[v].name, q_of(vt[v].bank), vt[v].exp);
    end

    // Retention through reset; write attempted during reset must be dropped
    idle_all();
    #2 resetn = 1'b0;
    #1;
    check("ret_reset_q15", q_of(15), 32'h0);
    set_bank(15, 1'b0, 1'b0, 8'd254, 32'hBEEF);
    tick();
    check("ret_reset_hold_q15", q_of(15), 32'h0);
    idle_all();
    #2 resetn = 1'b1;
    tick();
    set_bank(15, 1'b0, 1'b1, 8'd255, 32'h0);
    tick();
    check("ret_b15_255", q_of(15), 32'hDEAD);
    set_bank(15, 1'b0, 1'b1, 8'd254, 32'h0);
    tick();
    check("ret_b15_254_nowr", q_of(15), 32'h10D);
    idle_all();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
